// File: rtl/serial_tx_pkg.sv
// Shared encodings for the framed serial transmitter: controller states,
// shift-register modes and the bit shifted in behind the data.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_LOAD  = 2'd1,
    SR_SHIFT = 2'd2
  } sr_mode_e;

  localparam logic FILL_BIT = 1'b1;

endpackage

// File: rtl/serial_tx_ctrl_shift_reg_ar.sv
// Parallel-load / serial-shift register, shifting toward bit 0 with s_in_i
// entering at the top. Asynchronous active-high reset to zero.
module shift_reg_ar
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             s_in_i,
  input  logic [WIDTH-1:0] p_in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode_i)
      SR_LOAD:  q_d = p_in_i;
      SR_SHIFT: q_d = {s_in_i, q_q[WIDTH-1:1]};
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_tx_ctrl.sv
// Framed serial transmitter: accepts a word per valid/ready handshake, sends
// it LSB-first with a frame flag, then enforces GAP idle cycles.
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     in_ready_o,
  output logic                     s_out_o,
  output logic                     frame_o,
  output logic                     done_o,
  output logic [$clog2(WIDTH)-1:0] bit_idx_o
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_e          state_q;
  logic [IDXW-1:0] bit_idx_q;
  logic [WIDTH-1:0] sr_q;
  logic [1:0]      sr_mode;
  logic            last_bit;
  logic            accept;
  logic            gap_zero;
  logic            unused_sr_hi;

  assign last_bit   = (state_q == ST_SHIFT) && (bit_idx_q == LAST_IDX);
  // With no gap the next word may be taken during the last bit, keeping frame high.
  assign in_ready_o = (state_q == ST_IDLE) || ((GAP == 0) && last_bit);
  assign accept     = in_valid_i && in_ready_o;

  assign frame_o   = (state_q == ST_SHIFT);
  assign s_out_o   = frame_o ? sr_q[0] : 1'b1;
  assign done_o    = last_bit;
  assign bit_idx_o = frame_o ? bit_idx_q : '0;

  always_comb begin
    sr_mode = SR_HOLD;
    if (accept)                     sr_mode = SR_LOAD;
    else if (state_q == ST_SHIFT)   sr_mode = SR_SHIFT;
  end

  shift_reg_ar #(.WIDTH(WIDTH)) u_sr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .mode_i (sr_mode),
    .s_in_i (FILL_BIT),
    .p_in_i (in_data_i),
    .q_o    (sr_q)
  );

  assign unused_sr_hi = ^sr_q[WIDTH-1:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_SHIFT;
            bit_idx_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end else if (accept) begin
            bit_idx_q <= '0;
          end else if (GAP > 0) begin
            state_q   <= ST_GAP;
            bit_idx_q <= '0;
          end else begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
          end
        end
        ST_GAP: begin
          if (gap_zero) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      localparam int GW = $clog2(GAP + 1);
      logic [GW-1:0] gap_cnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          gap_cnt_q <= '0;
        else if (last_bit)
          gap_cnt_q <= GW'(GAP - 1);
        else if ((state_q == ST_GAP) && (gap_cnt_q != '0))
          gap_cnt_q <= gap_cnt_q - 1'b1;
      end

      assign gap_zero = (gap_cnt_q == '0);
    end else begin : g_nogap
      assign gap_zero = 1'b1;
    end
  endgenerate

endmodule
